// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider.
// One quotient bit per clock, start/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The running remainder never reaches the divisor, so WIDTH bits
  // hold it; the shifted value and the trial need one extra bit.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;

  // One restoring step: shift in the next dividend bit, try subtract.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[WIDTH];
    rem_nx  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nx  = {dvd_q[WIDTH-2:0], qbit};
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (dvs_q == '0) begin
          quo_d   = '1;
          rout_d  = dvd_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          rem_d = rem_nx;
          dvd_d = dvd_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quo_d   = dvd_nx;
            rout_d  = rem_nx;
            dbz_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rout_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider.
// Directed vectors, monitor pops expected results on done.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dz;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_q = 0;
  int   hold_r = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // Monitor: compare on done, check outputs hold while busy.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got q=%0d r=%0d want no done",
                 quotient, remainder);
      end else begin
        e = sbq.pop_front();
        chk("quotient", int'(quotient), e.q);
        chk("remainder", int'(remainder), e.r);
        chk("div_by_zero", int'(div_by_zero), e.dz);
        chk("latency", cyc - e.acc, (e.dz != 0) ? 1 : W);
        hold_q = e.q;
        hold_r = e.r;
      end
    end else if (busy && !rst) begin
      chk("hold_quotient", int'(quotient), hold_q);
      chk("hold_remainder", int'(remainder), hold_r);
    end
  end

  task automatic push(int av, int bv, int eq, int er, int edz);
    exp_t e;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.acc = cyc + 1;
    sbq.push_back(e);
    a = W'(av);
    b = W'(bv);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", n, 0);
  endtask

  // Single division; also counts busy cycles until done.
  task automatic do_div(int av, int bv, int eq, int er, int edz);
    int bc = 0;
    int n = 0;
    wait_idle();
    push(av, bv, eq, er, edz);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = '1;
    b = '1;
    forever begin
      @(negedge clk);
      if (busy) bc++;
      if (done || n > 100) break;
      n++;
    end
    chk("done_seen", int'(done), 1);
    chk("busy_cycles", bc, (edz != 0) ? 1 : W);
  endtask

  // Back-to-back burst with start held high.
  int bv_a[10]  = '{200, 255, 13, 81, 100, 7, 128, 250, 99, 173};
  int bv_b[10]  = '{7, 16, 0, 9, 10, 200, 3, 25, 0, 11};
  int bv_q[10]  = '{28, 15, 255, 9, 10, 0, 42, 10, 255, 15};
  int bv_r[10]  = '{4, 15, 13, 0, 0, 7, 2, 0, 99, 8};
  int bv_dz[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);

    do_div(200, 7, 28, 4, 0);
    do_div(255, 1, 255, 0, 0);
    do_div(5, 9, 0, 5, 0);
    do_div(0, 3, 0, 0, 0);
    do_div(77, 77, 1, 0, 0);
    do_div(100, 0, 255, 100, 1);
    do_div(9, 3, 3, 0, 0);

    // start during RUN must be ignored
    wait_idle();
    push(200, 7, 28, 4, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd50;
    b = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_drain", sbq.size(), 0);
    repeat (15) @(negedge clk);

    // reset mid-run aborts the division
    wait_idle();
    push(200, 7, 28, 4, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    hold_q = 0;
    hold_r = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    repeat (15) @(negedge clk);
    do_div(81, 9, 9, 0, 0);

    // burst: each accept happens on an edge where busy is low
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      push(bv_a[i], bv_b[i], bv_q[i], bv_r[i], bv_dz[i]);
      @(posedge clk);
      @(negedge clk);
    end
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("burst_drain", sbq.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
